// File: rtl/req_rr_scheduler.sv
// Round-robin arbiter with bounded hold time: grants one requester at a time,
// forces release after MAX_HOLD cycles and always inserts an idle cycle between grants.
module req_rr_scheduler #(
   parameter int N        = 8,
   parameter int IDXW     = 3,
   parameter int MAX_HOLD = 16,
   parameter int CNTW     = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    grant,
   output logic [IDXW-1:0] grant_idx,
   output logic            grant_valid,
   output logic            preempt,
   output logic [IDXW-1:0] last_idx
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_reg, state_next;
   logic [N-1:0]    grant_reg, grant_next;
   logic [IDXW-1:0] idx_reg, idx_next;
   logic            valid_reg, valid_next;
   logic            preempt_reg, preempt_next;
   logic [IDXW-1:0] last_reg, last_next;
   logic [CNTW-1:0] cnt_reg, cnt_next;

   logic            pick_found;
   logic [IDXW-1:0] pick_idx;
   logic [IDXW-1:0] cand_idx;
   int              cand;

   logic            hold_req;
   logic            rel_en;
   logic            rel_req;
   logic            rel_timeout;
   logic            release_now;

   // Search starts just past the last released index and covers all N slots,
   // so a lone requester equal to last_idx is still found.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 1; i <= N; i++) begin
         cand     = (int'(last_reg) + i) % N;
         cand_idx = IDXW'(cand);
         if (!pick_found && req[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   assign hold_req    = req[idx_reg];
   assign rel_en      = !en;
   assign rel_req     = !hold_req;
   assign rel_timeout = (cnt_reg == CNTW'(MAX_HOLD - 1));
   assign release_now = rel_en || rel_req || rel_timeout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         grant_reg   <= '0;
         idx_reg     <= '0;
         valid_reg   <= 1'b0;
         preempt_reg <= 1'b0;
         last_reg    <= IDXW'(N - 1);
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         grant_reg   <= grant_next;
         idx_reg     <= idx_next;
         valid_reg   <= valid_next;
         preempt_reg <= preempt_next;
         last_reg    <= last_next;
         cnt_reg     <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (en && pick_found) state_next = GRANT;
         GRANT:   if (release_now)      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      grant_next   = grant_reg;
      idx_next     = idx_reg;
      valid_next   = valid_reg;
      preempt_next = 1'b0;
      last_next    = last_reg;
      cnt_next     = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (en && pick_found) begin
               grant_next = {{(N-1){1'b0}}, 1'b1} << pick_idx;
               idx_next   = pick_idx;
               valid_next = 1'b1;
               cnt_next   = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               grant_next   = '0;
               idx_next     = '0;
               valid_next   = 1'b0;
               last_next    = idx_reg;
               cnt_next     = '0;
               // Timeout flags a preempt only when the holder still wants the resource.
               preempt_next = rel_timeout && !rel_en && !rel_req;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            grant_next = '0;
            idx_next   = '0;
            valid_next = 1'b0;
            cnt_next   = '0;
         end
      endcase
   end

   assign grant       = grant_reg;
   assign grant_idx   = idx_reg;
   assign grant_valid = valid_reg;
   assign preempt     = preempt_reg;
   assign last_idx    = last_reg;

endmodule

// File: tb/tb_req_rr_scheduler.sv
// Directed bench for req_rr_scheduler: reset, wrap-around, full rotation with
// timeouts, enable release, release priority and asynchronous reset.
module tb_req_rr_scheduler;

   localparam int N    = 8;
   localparam int IDXW = 3;

   logic            clk;
   logic            rst;
   logic            en;
   logic [N-1:0]    req;
   logic [N-1:0]    grant;
   logic [IDXW-1:0] grant_idx;
   logic            grant_valid;
   logic            preempt;
   logic [IDXW-1:0] last_idx;

   int checks = 0;
   int errors = 0;

   req_rr_scheduler #(.N(N), .IDXW(IDXW), .MAX_HOLD(16), .CNTW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .preempt     (preempt),
      .last_idx    (last_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [N-1:0] g,
                             input logic [IDXW-1:0] idx, input logic pre);
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
      check({tag, ".valid"}, 32'(grant_valid), 32'(|g));
      check({tag, ".preempt"}, 32'(preempt), 32'(pre));
      $display("%-10s t=%0t req=%02h grant=%02h idx=%0d valid=%0b pre=%0b last=%0d",
               tag, $time, req, grant, grant_idx, grant_valid, preempt, last_idx);
   endtask

   initial begin
      logic [N-1:0] one_hot;

      // 1: reset and idle with no requests
      rst = 1'b0;
      en  = 1'b1;
      req = '0;
      #13;
      expect_out("rst", 8'h00, 3'd0, 1'b0);
      check("rst.last", 32'(last_idx), 32'd7);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_out("idle0", 8'h00, 3'd0, 1'b0);
      end
      check("idle0.last", 32'(last_idx), 32'd7);

      // 2: two requesters, release by dropping the request, one-cycle gap
      req = 8'h81;
      tick();
      expect_out("t2.g0", 8'h01, 3'd0, 1'b0);
      req = 8'h80;
      tick();
      expect_out("t2.gap", 8'h00, 3'd0, 1'b0);
      check("t2.last0", 32'(last_idx), 32'd0);
      tick();
      expect_out("t2.g7", 8'h80, 3'd7, 1'b0);
      req = 8'h00;
      tick();
      expect_out("t2.rel7", 8'h00, 3'd0, 1'b0);
      check("t2.last7", 32'(last_idx), 32'd7);

      // lone requester equal to last_idx is still granted
      req = 8'h80;
      tick();
      expect_out("wrap.g7", 8'h80, 3'd7, 1'b0);
      req = 8'h00;
      tick();
      expect_out("wrap.rel", 8'h00, 3'd0, 1'b0);

      // 3: all requesting -> rotation with 16-cycle holds and preempt
      req = 8'hFF;
      for (int r = 0; r < 9; r++) begin
         one_hot = 8'h01 << (r % 8);
         tick();
         expect_out("rr.grant", one_hot, 3'(r % 8), 1'b0);
         for (int c = 1; c < 16; c++) begin
            tick();
            check("rr.hold", 32'(grant), 32'(one_hot));
            check("rr.nopre", 32'(preempt), 32'd0);
         end
         tick();
         expect_out("rr.preempt", 8'h00, 3'd0, 1'b1);
         check("rr.last", 32'(last_idx), 32'(r % 8));
      end
      req = 8'h00;
      tick();
      expect_out("rr.pulse", 8'h00, 3'd0, 1'b0);

      // 4: en=0 during a grant on idx 3
      req = 8'h08;
      tick();
      expect_out("t4.g3", 8'h08, 3'd3, 1'b0);
      for (int c = 0; c < 4; c++) tick();
      check("t4.held", 32'(grant), 32'h08);
      en = 1'b0;
      tick();
      expect_out("t4.rel", 8'h00, 3'd0, 1'b0);
      check("t4.last", 32'(last_idx), 32'd3);
      for (int c = 0; c < 3; c++) begin
         tick();
         expect_out("t4.off", 8'h00, 3'd0, 1'b0);
      end
      en  = 1'b1;
      req = 8'h00;
      tick();

      // 5: request drops on the timeout edge -> normal release, no preempt
      req = 8'h04;
      tick();
      expect_out("t5.g2", 8'h04, 3'd2, 1'b0);
      for (int c = 1; c < 16; c++) tick();
      check("t5.held", 32'(grant), 32'h04);
      req = 8'h00;
      tick();
      expect_out("t5.rel", 8'h00, 3'd0, 1'b0);
      check("t5.last", 32'(last_idx), 32'd2);
      tick();
      expect_out("t5.idle", 8'h00, 3'd0, 1'b0);

      // 6: asynchronous reset mid-grant
      req = 8'h20;
      tick();
      expect_out("t6.g5", 8'h20, 3'd5, 1'b0);
      tick();
      #2;
      rst = 1'b0;
      #1;
      expect_out("t6.arst", 8'h00, 3'd0, 1'b0);
      check("t6.last", 32'(last_idx), 32'd7);
      req = 8'h18;
      tick();
      expect_out("t6.hold", 8'h00, 3'd0, 1'b0);
      rst = 1'b1;
      tick();
      expect_out("t6.g3", 8'h08, 3'd3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
